// File: rtl/ram_arbiter2_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
// Both the top level and the round-robin picker import this package.
package ram_arbiter2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Index of the requester that is not `idx`.
  function automatic logic other_req(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/ram_arbiter2_arb_rr2.sv
// Combinational two-way round-robin picker.
// When both requesters ask, the one that was not served last wins.
module arb_rr2
  import ram_arbiter2_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = other_req(last);
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter2.sv
// Two-requester round-robin arbiter in front of one single-port word RAM,
// with a per-transaction watchdog that aborts an access the RAM never answers.
module ram_arbiter2
  import ram_arbiter2_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  input  logic [3:0]        r0_wstrb,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  input  logic [3:0]        r1_wstrb,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_e        state_q;
  logic              grant_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              r0_ready_q;
  logic              r1_ready_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;

  logic [1:0]        req;
  logic              pick_valid;
  logic              pick_idx;
  logic              timeout_hit;
  logic              load_en_d;
  logic              load_idx_d;
  logic [ADDR_W-1:0] load_addr_d;
  logic [31:0]       load_wdata_d;
  logic [3:0]        load_wstrb_d;

  assign req         = {r1_valid, r0_valid};
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  arb_rr2 u_pick (
    .req       (req),
    .last      (last_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // In RESP only the other requester may be loaded; the one just served
  // still holds valid this cycle and must not be granted again.
  always_comb begin
    load_en_d  = 1'b0;
    load_idx_d = pick_idx;
    if (state_q == ST_IDLE) begin
      load_en_d = pick_valid;
    end else if (state_q == ST_RESP) begin
      load_idx_d = other_req(grant_q);
      load_en_d  = req[load_idx_d];
    end
    load_addr_d  = load_idx_d ? r1_addr  : r0_addr;
    load_wdata_d = load_idx_d ? r1_wdata : r0_wdata;
    load_wstrb_d = load_idx_d ? r1_wstrb : r0_wstrb;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      r0_ready_q  <= 1'b0;
      r1_ready_q  <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: ;
        ST_BUSY: begin
          if (mem_ready || timeout_hit) begin
            state_q     <= ST_RESP;
            mem_valid_q <= 1'b0;
            rdata_q     <= mem_ready ? mem_rdata : ERR_DATA;
            err_q       <= ~mem_ready;
            r0_ready_q  <= ~grant_q;
            r1_ready_q  <= grant_q;
          end else if (TIMEOUT > 0) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          last_q <= grant_q;
          if (!load_en_d) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (load_en_d) begin
        state_q     <= ST_BUSY;
        grant_q     <= load_idx_d;
        cnt_q       <= '0;
        mem_valid_q <= 1'b1;
        mem_addr_q  <= load_addr_d;
        mem_wdata_q <= load_wdata_d;
        mem_wstrb_q <= load_wstrb_d;
      end
    end
  end

  assign r0_ready  = r0_ready_q;
  assign r1_ready  = r1_ready_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule
